led_channel_scanner: RTL

Parametrised one-hot LED channel selector for the Basys3 board. It selects one of N = 2**SEL_W channels and gates a data word onto the LEDs with that one-hot mask. Selection comes from a registered manual input or from a built-in auto-scan counter driven by a prescaled tick; an all-on mode is also provided. It sits between the switch/button inputs and the board LED pins, and all outputs are registered.

---
 rtl/led_scan_pkg.sv | 13 +
 rtl/led_channel_scanner_prescaler.sv | 32 +++
 rtl/led_channel_scanner.sv | 82 ++++++++
 3 files changed

// File: rtl/led_scan_pkg.sv
// Shared definitions for the LED channel scanner: mode encodings and a mode helper.
package led_scan_pkg;

    localparam logic [1:0] MODE_MANUAL    = 2'b00;
    localparam logic [1:0] MODE_SCAN_UP   = 2'b01;
    localparam logic [1:0] MODE_SCAN_DOWN = 2'b10;
    localparam logic [1:0] MODE_ALL_ON    = 2'b11;

    function automatic logic is_scan_mode(input logic [1:0] mode);
        return (mode == MODE_SCAN_UP) || (mode == MODE_SCAN_DOWN);
    endfunction

endpackage

// File: rtl/led_channel_scanner_prescaler.sv
// Free-running 0..PRESCALE-1 counter; tick flags the wrap cycle (combinational,
// the top registers it). clr or en=0 hold the count at zero and suppress tick.
module tick_prescaler #(
    parameter int PRESCALE = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_pcnt;
    logic             w_last;

    assign w_last = (r_pcnt == LAST);
    assign tick   = en && !clr && w_last;

    always_ff @(posedge clk) begin
        if (rst || clr || !en) begin
            r_pcnt <= '0;
        end else if (w_last) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_channel_scanner.sv
// One-hot LED channel selector: manual select, auto scan up/down on a prescaled
// step, or all-on; led is the registered mask-gated data word.
module led_channel_scanner
    import led_scan_pkg::*;
#(
    parameter int SEL_W    = 2,
    parameter int PRESCALE = 25_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic                sel_load,
    input  logic [2**SEL_W-1:0] data,
    output logic [2**SEL_W-1:0] led,
    output logic [SEL_W-1:0]    cur_sel,
    output logic                tick
);

    localparam int N = 2**SEL_W;

    logic [SEL_W-1:0] r_cur_sel;
    logic [N-1:0]     r_led;
    logic             r_tick;
    logic [1:0]       r_mode;

    logic             w_scan;
    logic             w_mode_chg;
    logic             w_clr;
    logic             w_step;
    logic [N-1:0]     w_mask;

    assign w_scan     = is_scan_mode(mode);
    assign w_mode_chg = (mode != r_mode);
    // A load or a mode switch restarts the scan period from a full count.
    assign w_clr      = sel_load || w_mode_chg;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (w_scan),
        .clr  (w_clr),
        .tick (w_step)
    );

    always_comb begin
        w_mask = N'(1) << r_cur_sel;
        if (mode == MODE_ALL_ON) begin
            w_mask = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_sel <= '0;
            r_led     <= '0;
            r_tick    <= 1'b0;
            r_mode    <= MODE_MANUAL;
        end else begin
            r_mode <= mode;
            r_tick <= w_step;
            r_led  <= w_mask & data;
            // w_step is already masked by sel_load, so a load always wins.
            if (sel_load) begin
                r_cur_sel <= sel;
            end else if (w_step) begin
                if (mode == MODE_SCAN_UP) begin
                    r_cur_sel <= r_cur_sel + SEL_W'(1);
                end else begin
                    r_cur_sel <= r_cur_sel - SEL_W'(1);
                end
            end
        end
    end

    assign led     = r_led;
    assign cur_sel = r_cur_sel;
    assign tick    = r_tick;

endmodule
